// File: rtl/floating_point_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : floating_point_aligner
//  Description : Aligns the mantissas of two unsigned IEEE-754 single values
//                (sign removed) to a common exponent. The mantissa with the
//                smaller effective exponent is logically right-shifted by up
//                to STEP bits per cycle until both share the larger exponent.
//                One operation is held at a time (IDLE -> SHIFT -> DONE).
//  Ports       : clk, reset (async, active-high)
//                a, b          [30:0] operands, [30:23] exponent, [22:0] frac
//                in_valid/in_ready      input handshake (ready only in IDLE)
//                a_mant, b_mant [23:0]  aligned mantissas incl. hidden bit
//                exp [7:0]              common exponent
//                out_valid/out_ready    output handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module floating_point_aligner #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [30:0] a,
    input  logic [30:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] a_mant,
    output logic [23:0] b_mant,
    output logic [7:0]  exp,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [4:0] C_STEP    = 5'(STEP);
    localparam logic [4:0] C_MAX_REM = 5'd24;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [4:0] r_remaining;
    logic       r_target_a;
    logic       r_target_b;

    // ------------------------------------------------------------------
    // Operand decode for the accept cycle
    // ------------------------------------------------------------------
    logic [7:0] w_exp_a, w_exp_b;
    logic [7:0] w_eff_a, w_eff_b;
    logic       w_hid_a, w_hid_b;
    logic       w_a_smaller, w_b_smaller;
    logic [7:0] w_diff;
    logic [4:0] w_rem0;
    logic [4:0] w_k;

    assign w_exp_a = a[30:23];
    assign w_exp_b = b[30:23];
    assign w_hid_a = |w_exp_a;
    assign w_hid_b = |w_exp_b;
    // Denormals share the exponent of the smallest normal for alignment.
    assign w_eff_a = w_hid_a ? w_exp_a : 8'd1;
    assign w_eff_b = w_hid_b ? w_exp_b : 8'd1;

    assign w_a_smaller = (w_eff_a < w_eff_b);
    assign w_b_smaller = (w_eff_b < w_eff_a);
    assign w_diff      = w_a_smaller ? (w_eff_b - w_eff_a) : (w_eff_a - w_eff_b);
    // Shifting by 24 or more clears a 24-bit mantissa, so cap the count.
    assign w_rem0      = (w_diff > 8'd24) ? C_MAX_REM : w_diff[4:0];

    // Shift amount for this cycle: whatever is left, at most STEP.
    assign w_k = (r_remaining < C_STEP) ? r_remaining : C_STEP;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_next_state = (w_rem0 == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_remaining == w_k) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // out_ready only counts once the result is being presented.
                if (out_valid && out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = (r_state == IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_mant      <= 24'd0;
            b_mant      <= 24'd0;
            exp         <= 8'd0;
            out_valid   <= 1'b0;
            r_remaining <= 5'd0;
            r_target_a  <= 1'b0;
            r_target_b  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        a_mant      <= {w_hid_a, a[22:0]};
                        b_mant      <= {w_hid_b, b[22:0]};
                        exp         <= (w_exp_a > w_exp_b) ? w_exp_a : w_exp_b;
                        r_remaining <= w_rem0;
                        r_target_a  <= w_a_smaller;
                        r_target_b  <= w_b_smaller;
                    end
                end
                SHIFT: begin
                    if (r_target_a) begin
                        a_mant <= a_mant >> w_k;
                    end
                    if (r_target_b) begin
                        b_mant <= b_mant >> w_k;
                    end
                    r_remaining <= r_remaining - w_k;
                end
                DONE: begin
                    // First DONE cycle presents the result; it is then held
                    // until the consumer takes it.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
